residual_fifo: RTL and testbench

Parametrised first-in-first-out residual store between the LPC encoder and the Rice/residual coder. It accepts signed residuals with a block-end tag and returns them in arrival order through valid/ready handshakes on both sides. It tracks full/empty, occupancy and the number of complete blocks held, so the downstream coder can start only when a whole block is present. Overflow is flagged rather than silently corrupting data.

---
 rtl/residual_fifo_pkg.sv | 20 ++
 rtl/residual_fifo_ram.sv | 29 ++
 rtl/residual_fifo.sv | 124 ++++++++++++
 tb/tb_residual_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/residual_fifo_pkg.sv
// Shared constants and helpers for the residual FIFO between the LPC encoder
// and the Rice/residual coder.
package residual_fifo_pkg;

    localparam int RESIDUAL_WIDTH      = 16;
    localparam int RESIDUAL_FIFO_DEPTH = 16;

    // Encoding is {write, read} so the helper below can build it by concatenation.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic wr, input logic rd);
        return fifo_op_e'({wr, rd});
    endfunction

endpackage

// File: rtl/residual_fifo_ram.sv
// Simple dual-port storage for the residual FIFO: synchronous write,
// asynchronous read, intended to map onto distributed RAM.
module residual_fifo_ram
    import residual_fifo_pkg::*;
#(
    parameter int DW    = RESIDUAL_WIDTH + 1,
    parameter int DEPTH = RESIDUAL_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          iClock,
    input  logic          iWrEn,
    input  logic [AW-1:0] iWrAddr,
    input  logic [DW-1:0] iWrData,
    input  logic [AW-1:0] iRdAddr,
    output logic [DW-1:0] oRdData
);

    // No reset on storage: contents are only meaningful behind the pointers.
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge iClock) begin
        if (iWrEn) begin
            mem_q[iWrAddr] <= iWrData;
        end
    end

    assign oRdData = mem_q[iRdAddr];

endmodule

// File: rtl/residual_fifo.sv
// First-word fall-through residual FIFO with block-end tags, occupancy and
// complete-block counts, and a sticky overflow flag.
module residual_fifo
    import residual_fifo_pkg::*;
#(
    parameter int WIDTH = RESIDUAL_WIDTH,
    parameter int DEPTH = RESIDUAL_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                    iClock,
    input  logic                    iReset,
    input  logic                    iFlush,
    input  logic                    iValid,
    input  logic                    iLast,
    input  logic signed [WIDTH-1:0] iResidual,
    output logic                    oReady,
    output logic                    oValid,
    output logic signed [WIDTH-1:0] oResidual,
    output logic                    oLast,
    input  logic                    iReady,
    output logic [AW:0]             oCount,
    output logic [AW:0]             oBlocks,
    output logic                    oOverflow
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [AW:0]    blocks_q, blocks_d;
    logic           overflow_q, overflow_d;

    logic           full, empty;
    logic           wr_fire, rd_fire;
    logic [WIDTH:0] head_entry;
    fifo_op_e       op;

    // Wrap bit differs and index matches -> full; identical pointers -> empty.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Flush discards any same-cycle transfer, including the RAM write.
    assign wr_fire = iValid && !full && !iFlush;
    assign rd_fire = iReady && !empty && !iFlush;
    assign op      = fifo_op(wr_fire, rd_fire);

    residual_fifo_ram #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .iClock  (iClock),
        .iWrEn   (wr_fire),
        .iWrAddr (wr_ptr_q[AW-1:0]),
        .iWrData ({iLast, iResidual}),
        .iRdAddr (rd_ptr_q[AW-1:0]),
        .oRdData (head_entry)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        blocks_d   = blocks_q;
        overflow_d = overflow_q;

        if (iFlush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            blocks_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (iValid && full) begin
                overflow_d = 1'b1;
            end
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            unique case (op)
                OP_PUSH: count_d = count_q + 1'b1;
                OP_POP:  count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            blocks_d = blocks_q + (AW+1)'(wr_fire && iLast)
                                - (AW+1)'(rd_fire && head_entry[WIDTH]);
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            blocks_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            blocks_q   <= blocks_d;
            overflow_q <= overflow_d;
        end
    end

    assign oReady    = !full;
    assign oValid    = !empty;
    assign oResidual = head_entry[WIDTH-1:0];
    assign oLast     = head_entry[WIDTH];
    assign oCount    = count_q;
    assign oBlocks   = blocks_q;
    assign oOverflow = overflow_q;

    // Pointer-derived flags and the occupancy counter are kept independently.
    assert property (@(posedge iClock) disable iff (iReset)
        (full == (count_q == FULL_COUNT)) && (empty == (count_q == '0)));

endmodule

// File: tb/tb_residual_fifo.sv
// Directed-vector bench for residual_fifo with hand-computed expectations.
module tb_residual_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic                    iClock = 1'b0;
    logic                    iReset = 1'b0;
    logic                    iFlush = 1'b0;
    logic                    iValid = 1'b0;
    logic                    iLast  = 1'b0;
    logic signed [WIDTH-1:0] iResidual = '0;
    logic                    oReady;
    logic                    oValid;
    logic signed [WIDTH-1:0] oResidual;
    logic                    oLast;
    logic                    iReady = 1'b0;
    logic [AW:0]             oCount;
    logic [AW:0]             oBlocks;
    logic                    oOverflow;

    int vectors     = 0;
    int miscompares = 0;

    residual_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .iClock    (iClock),
        .iReset    (iReset),
        .iFlush    (iFlush),
        .iValid    (iValid),
        .iLast     (iLast),
        .iResidual (iResidual),
        .oReady    (oReady),
        .oValid    (oValid),
        .oResidual (oResidual),
        .oLast     (oLast),
        .iReady    (iReady),
        .oCount    (oCount),
        .oBlocks   (oBlocks),
        .oOverflow (oOverflow)
    );

    always #5 iClock = ~iClock;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic push(input int val, input logic last);
        iValid    = 1'b1;
        iResidual = WIDTH'(val);
        iLast     = last;
        tick();
        iValid    = 1'b0;
        iLast     = 1'b0;
    endtask

    task automatic pop();
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
    endtask

    task automatic flush();
        iFlush = 1'b1;
        tick();
        iFlush = 1'b0;
    endtask

    initial begin
        int fill_vals[DEPTH];

        // Reset state
        #1 iReset = 1'b1;
        #2;
        chk("rst_ready", oReady, 1);
        chk("rst_valid", oValid, 0);
        chk("rst_count", oCount, 0);
        chk("rst_blocks", oBlocks, 0);
        chk("rst_ovf", oOverflow, 0);
        @(negedge iClock);
        iReset = 1'b0;
        tick();

        // Three residuals, consumer stalled, then drained in order
        push(-5, 1'b0);
        chk("lat_valid", oValid, 1);
        chk("lat_head", oResidual, -5);
        push(7, 1'b0);
        push(32767, 1'b1);
        chk("t1_count", oCount, 3);
        chk("t1_blocks", oBlocks, 1);
        chk("t1_head", oResidual, -5);
        iReady = 1'b1;
        chk("t1_rd0", oResidual, -5);
        chk("t1_rd0_last", oLast, 0);
        tick();
        chk("t1_rd1", oResidual, 7);
        chk("t1_rd1_last", oLast, 0);
        tick();
        chk("t1_rd2", oResidual, 32767);
        chk("t1_rd2_last", oLast, 1);
        tick();
        iReady = 1'b0;
        chk("t1_empty_valid", oValid, 0);
        chk("t1_empty_count", oCount, 0);
        chk("t1_empty_blocks", oBlocks, 0);

        // Fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            fill_vals[i] = -8000 + i * 1000;
            push(fill_vals[i], 1'b0);
        end
        chk("full_ready", oReady, 0);
        chk("full_count", oCount, 16);
        chk("full_ovf_pre", oOverflow, 0);
        push(32'h1234, 1'b0);
        chk("ovf_flag", oOverflow, 1);
        chk("ovf_count", oCount, 16);
        chk("ovf_head", oResidual, fill_vals[0]);
        // Write refused while full even with a same-cycle read
        iValid    = 1'b1;
        iResidual = 16'h1234;
        iReady    = 1'b1;
        tick();
        iValid = 1'b0;
        chk("full_rw_count", oCount, 15);
        chk("full_rw_head", oResidual, fill_vals[1]);
        for (int i = 1; i < DEPTH; i++) begin
            chk("drain_head", oResidual, fill_vals[i]);
            tick();
        end
        iReady = 1'b0;
        chk("drain_empty", oValid, 0);
        chk("ovf_sticky", oOverflow, 1);
        flush();
        chk("flush_ovf_clr", oOverflow, 0);

        // Sustained simultaneous read/write at occupancy 3, wrapping pointers
        for (int i = 0; i < 3; i++) push(1000 + i, 1'b0);
        for (int k = 0; k < 100; k++) begin
            iValid    = 1'b1;
            iResidual = WIDTH'(1003 + k);
            iReady    = 1'b1;
            chk("stream_head", oResidual, 1000 + k);
            tick();
            chk("stream_count", oCount, 3);
        end
        iValid = 1'b0;
        iReady = 1'b0;
        flush();
        chk("flush_count", oCount, 0);

        // Block counting: two blocks of four
        for (int i = 0; i < 8; i++) begin
            push(i - 4, (i == 3) || (i == 7));
            chk("blk_wr", oBlocks, (i >= 7) ? 2 : (i >= 3) ? 1 : 0);
        end
        for (int i = 0; i < 5; i++) begin
            chk("blk_head", oResidual, i - 4);
            pop();
            chk("blk_rd", oBlocks, (i >= 3) ? 1 : 2);
        end
        chk("blk_count", oCount, 3);

        // Flush at occupancy 9 with a same-cycle write and read
        for (int i = 0; i < 6; i++) push(200 + i, 1'b1);
        chk("pre_flush_count", oCount, 9);
        iFlush    = 1'b1;
        iValid    = 1'b1;
        iReady    = 1'b1;
        iResidual = 16'sd77;
        tick();
        iFlush = 1'b0;
        iValid = 1'b0;
        iReady = 1'b0;
        chk("flush9_count", oCount, 0);
        chk("flush9_blocks", oBlocks, 0);
        chk("flush9_ovf", oOverflow, 0);
        chk("flush9_valid", oValid, 0);

        // Asynchronous reset between edges, from a full and overflowed state
        for (int i = 0; i < DEPTH; i++) push(i, (i % 4) == 3);
        push(5, 1'b0);
        chk("pre_rst_ovf", oOverflow, 1);
        chk("pre_rst_blocks", oBlocks, 4);
        #3 iReset = 1'b1;
        #1;
        chk("arst_ready", oReady, 1);
        chk("arst_valid", oValid, 0);
        chk("arst_count", oCount, 0);
        chk("arst_blocks", oBlocks, 0);
        chk("arst_ovf", oOverflow, 0);
        #2 iReset = 1'b0;
        tick();
        push(-1, 1'b1);
        chk("post_rst_head", oResidual, -1);
        chk("post_rst_count", oCount, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
